// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Run/halt/step clock-enable and program-load controller for the
//            4-bit CPU core. Optional breakpoint logic: CPU_RUN_CTRL_BRK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
  parameter int DIV     = 4,
  parameter int RST_CYC = 2
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       cmd_run_i,
  input  logic       cmd_halt_i,
  input  logic       cmd_step_i,
  input  logic       load_valid_i,
  output logic       load_ready_o,
  input  logic [3:0] load_addr_i,
  input  logic [7:0] load_data_i,
  input  logic       load_last_i,
  output logic       mem_we_o,
  output logic [3:0] mem_waddr_o,
  output logic [7:0] mem_wdata_o,
  output logic       cpu_en_o,
  output logic       cpu_rst_n_o,
  input  logic [3:0] cpu_pc_i,
  input  logic       brk_valid_i,
  input  logic [3:0] brk_addr_i,
  output logic       brk_hit_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] c_ST_HALT  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_LOAD  = 2'd2;
  localparam logic [1:0] c_ST_CLR   = 2'd3;
  localparam logic [7:0] c_DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] c_RST_LAST = 8'(RST_CYC - 1);

  logic [1:0] state_q,  state_d;
  logic [7:0] presc_q,  presc_d;
  logic [7:0] rstcnt_q, rstcnt_d;
  logic       cpu_en_q, cpu_en_d;
  logic       rst_n_q,  rst_n_d;
  logic       ready_q,  ready_d;
  logic       we_q,     we_d;
  logic [3:0] waddr_q,  waddr_d;
  logic [7:0] wdata_q,  wdata_d;
  logic       step_d;
  logic       beat_acc;
`ifdef CPU_RUN_CTRL_BRK_EN
  logic       brk_hit_q, brk_hit_d;
  logic       first_q,   first_d;
`else
  logic       unused_brk;
  assign unused_brk = ^{brk_valid_i, brk_addr_i, cpu_pc_i};
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= c_ST_CLR;
      presc_q   <= 8'd0;
      rstcnt_q  <= 8'd0;
      cpu_en_q  <= 1'b0;
      rst_n_q   <= 1'b0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= 4'd0;
      wdata_q   <= 8'd0;
`ifdef CPU_RUN_CTRL_BRK_EN
      brk_hit_q <= 1'b0;
      first_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      rstcnt_q  <= rstcnt_d;
      cpu_en_q  <= cpu_en_d;
      rst_n_q   <= rst_n_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
`ifdef CPU_RUN_CTRL_BRK_EN
      brk_hit_q <= brk_hit_d;
      first_q   <= first_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    rstcnt_d = 8'd0;
    step_d   = 1'b0;
    beat_acc = load_valid_i && ready_q;
`ifdef CPU_RUN_CTRL_BRK_EN
    brk_hit_d = brk_hit_q;
    first_d   = first_q;
`endif
    case (state_q)
      c_ST_CLR: begin
        if (rstcnt_q == c_RST_LAST) state_d = c_ST_HALT;
        else                        rstcnt_d = rstcnt_q + 8'd1;
      end
      c_ST_HALT: begin
        if (beat_acc) begin
          state_d = load_last_i ? c_ST_CLR : c_ST_LOAD;
        end else if (!cmd_halt_i) begin
          if (cmd_step_i) begin
            step_d = 1'b1;
          end else if (cmd_run_i) begin
            state_d = c_ST_RUN;
            presc_d = 8'd0;
          end
        end
      end
      c_ST_RUN: begin
        presc_d = (presc_q == c_DIV_LAST) ? 8'd0 : presc_q + 8'd1;
        if (cmd_halt_i) begin
          state_d = c_ST_HALT;
          presc_d = 8'd0;
        end
      end
      default: begin
        if (beat_acc && load_last_i) state_d = c_ST_CLR;
      end
    endcase
`ifdef CPU_RUN_CTRL_BRK_EN
    if (beat_acc || step_d || (state_q == c_ST_HALT && state_d == c_ST_RUN))
      brk_hit_d = 1'b0;
    // The first pulse after entering RUN is never checked, so a run resumes past the breakpoint.
    if (state_d == c_ST_RUN) begin
      if (state_q != c_ST_RUN) first_d = 1'b1;
      if (presc_d == c_DIV_LAST) begin
        if (state_q == c_ST_RUN && !first_q && brk_valid_i && (cpu_pc_i == brk_addr_i)) begin
          state_d   = c_ST_HALT;
          presc_d   = 8'd0;
          brk_hit_d = 1'b1;
        end else begin
          first_d = 1'b0;
        end
      end
    end
`endif
  end

  always_comb begin
    cpu_en_d = step_d || (state_d == c_ST_RUN && presc_d == c_DIV_LAST);
    rst_n_d  = (state_d != c_ST_CLR);
    ready_d  = (state_d == c_ST_HALT) || (state_d == c_ST_LOAD);
    we_d     = beat_acc;
    waddr_d  = beat_acc ? load_addr_i : waddr_q;
    wdata_d  = beat_acc ? load_data_i : wdata_q;
  end

  assign load_ready_o = ready_q;
  assign mem_we_o     = we_q;
  assign mem_waddr_o  = waddr_q;
  assign mem_wdata_o  = wdata_q;
  assign cpu_en_o     = cpu_en_q;
  assign cpu_rst_n_o  = rst_n_q;
  assign state_o      = state_q;
`ifdef CPU_RUN_CTRL_BRK_EN
  assign brk_hit_o    = brk_hit_q;
`else
  assign brk_hit_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Purpose  : Self-checking bench for cpu_run_ctrl with a write-beat scoreboard
//            and a behavioural core PC. Honours CPU_RUN_CTRL_BRK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

  localparam int         DIV     = 4;
  localparam int         RST_CYC = 2;
  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_CLR  = 2'd3;

  logic       clock = 1'b0;
  logic       reset, cmd_run, cmd_halt, cmd_step;
  logic       load_valid, load_ready, load_last;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       cpu_en, cpu_rst_n;
  logic [3:0] pc = 4'd0;
  logic       brk_valid, brk_hit;
  logic [3:0] brk_addr;
  logic [1:0] state;

  cpu_run_ctrl #(.DIV(DIV), .RST_CYC(RST_CYC)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .cmd_run_i    (cmd_run),
    .cmd_halt_i   (cmd_halt),
    .cmd_step_i   (cmd_step),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data),
    .load_last_i  (load_last),
    .mem_we_o     (mem_we),
    .mem_waddr_o  (mem_waddr),
    .mem_wdata_o  (mem_wdata),
    .cpu_en_o     (cpu_en),
    .cpu_rst_n_o  (cpu_rst_n),
    .cpu_pc_i     (pc),
    .brk_valid_i  (brk_valid),
    .brk_addr_i   (brk_addr),
    .brk_hit_o    (brk_hit),
    .state_o      (state)
  );

  initial forever #5 clock = ~clock;

  // Behavioural core: PC advances on each enable, cleared while held in reset.
  always @(posedge clock) begin
    if (cpu_rst_n !== 1'b1)   pc <= 4'd0;
    else if (cpu_en === 1'b1) pc <= pc + 4'd1;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wr     = 0;
  logic [11:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_halt(output int cycles, output int bad);
    cycles = 0;
    bad    = 0;
    while (state !== ST_HALT && cycles < 20) begin
      if (cpu_en !== 1'b0 || cpu_rst_n !== 1'b0 || load_ready !== 1'b0) bad++;
      cycles++;
      tick();
    end
  endtask

  task automatic drive_beat(input logic [3:0] a, input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_last  = last;
    check("beat_ready", load_ready, 1);
    sb_q.push_back({a, d});
    tick();
  endtask

  // Scoreboard: every write strobe must match the oldest accepted beat.
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("we_unexpected", mem_we, 0);
      end else begin
        check("wr_beat", {mem_waddr, mem_wdata}, sb_q.pop_front());
        n_wr++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n, bad, pulses;
    logic [11:0] mask;
    reset = 1'b1; cmd_run = 1'b0; cmd_halt = 1'b0; cmd_step = 1'b0;
    load_valid = 1'b0; load_addr = 4'd0; load_data = 8'd0; load_last = 1'b0;
    brk_valid = 1'b0; brk_addr = 4'd0;

    // Reset state
    tick();
    check("rst_state", state, ST_CLR);
    check("rst_rst_n", cpu_rst_n, 0);
    check("rst_en", cpu_en, 0);
    check("rst_we", mem_we, 0);
    check("rst_ready", load_ready, 0);
    check("rst_brk", brk_hit, 0);
    reset = 1'b0;
    wait_halt(n, bad);
    check("rst_clr_cycles", n, RST_CYC);
    check("rst_clr_outputs", bad, 0);
    check("rst_halt_ready", load_ready, 1);
    check("rst_halt_rst_n", cpu_rst_n, 1);

    // Three-beat program load
    drive_beat(4'h0, 8'h31, 1'b0);
    check("ld_state", state, ST_LOAD);
    check("ld_first_we", mem_we, 1);
    drive_beat(4'h1, 8'hB3, 1'b0);
    drive_beat(4'hF, 8'hF0, 1'b1);
    load_valid = 1'b0; load_last = 1'b0;
    check("ld_last_we", mem_we, 1);
    check("ld_last_addr", mem_waddr, 4'hF);
    check("ld_done_state", state, ST_CLR);
    wait_halt(n, bad);
    check("ld_clr_cycles", n, RST_CYC);
    check("ld_clr_outputs", bad, 0);
    check("ld_writes", n_wr, 3);

    // Free run with DIV=4 for 12 cycles
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    check("run_state", state, ST_RUN);
    check("run_ready", load_ready, 0);
    mask = 12'd0;
    for (int k = 1; k <= 12; k++) begin
      mask[k-1] = cpu_en;
      if (k == 12) cmd_halt = 1'b1;
      tick();
    end
    cmd_halt = 1'b0;
    check("run_pulse_mask", mask, 12'h888);
    check("run_halt_state", state, ST_HALT);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      pulses += int'(cpu_en);
      tick();
    end
    check("run_after_halt", pulses, 0);

    // Halt in the cycle before a due pulse suppresses it
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    tick(); tick();
    cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
    check("halt_supp_en", cpu_en, 0);
    check("halt_supp_state", state, ST_HALT);

    // Single step, step+run, halt+step
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    check("step_en", cpu_en, 1);
    check("step_state", state, ST_HALT);
    tick();
    check("step_once", cpu_en, 0);
    cmd_step = 1'b1; cmd_run = 1'b1; tick(); cmd_step = 1'b0; cmd_run = 1'b0;
    check("steprun_en", cpu_en, 1);
    check("steprun_state", state, ST_HALT);
    tick();
    check("steprun_once", cpu_en, 0);
    check("steprun_stay", state, ST_HALT);
    cmd_halt = 1'b1; cmd_step = 1'b1; tick(); cmd_halt = 1'b0; cmd_step = 1'b0;
    check("haltstep_en", cpu_en, 0);

    // Load beat outranks step; then reset aborts the load
    cmd_step = 1'b1;
    drive_beat(4'h2, 8'hAA, 1'b0);
    cmd_step = 1'b0;
    check("ldpri_en", cpu_en, 0);
    check("ldpri_state", state, ST_LOAD);
    load_addr = 4'h3; load_data = 8'h55; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstld_we", mem_we, 0);
    check("rstld_state", state, ST_CLR);
    check("rstld_wdata", {mem_waddr, mem_wdata}, 12'h000);
    load_addr = 4'h4; load_data = 8'h66; load_last = 1'b1;
    n = 0;
    while (load_ready !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("rstld_holdoff", n, RST_CYC);
    drive_beat(4'h4, 8'h66, 1'b1);
    load_valid = 1'b0; load_last = 1'b0;
    check("rstld_beat_we", mem_we, 1);
    wait_halt(n, bad);
    check("rstld_clr_cycles", n, RST_CYC);

`ifdef CPU_RUN_CTRL_BRK_EN
    // Breakpoint at 5, then resume past it
    brk_valid = 1'b1; brk_addr = 4'd5;
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    pulses = 0; n = 0;
    while (state !== ST_HALT && n < 100) begin
      pulses += int'(cpu_en);
      n++;
      tick();
    end
    check("brk_pc", pc, 5);
    check("brk_hit", brk_hit, 1);
    check("brk_pulses", pulses, 5);
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    check("brk_clear", brk_hit, 0);
    check("brk_resume_state", state, ST_RUN);
    n = 0;
    while (pc == 4'd5 && n < 20) begin
      n++;
      tick();
    end
    check("brk_past_pc", pc, 6);
    check("brk_past_state", state, ST_RUN);
`else
    // Without breakpoint logic the armed inputs have no effect
    brk_valid = 1'b1; brk_addr = 4'd5;
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    n = 0;
    while (pc != 4'd7 && n < 60) begin
      n++;
      tick();
    end
    check("nobrk_pc", pc, 7);
    check("nobrk_hit", brk_hit, 0);
    check("nobrk_state", state, ST_RUN);
`endif
    cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
    check("final_halt", state, ST_HALT);
    tick(); tick();
    check("sb_empty", sb_q.size(), 0);
    check("sb_writes", n_wr, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/load controller for the 4-bit CPU core. Gates the core's execution with a single-cycle clock-enable pulse train (run, halt, single-step), owns the program-memory write port so a host can load a 16×8 program while the core is halted, and holds the core in reset around every load. Sits between the board/host control interface and the `cpu` core plus its program memory.

## Interface
- `DIV`, 4: run-mode prescaler; one `cpu_en` pulse every `DIV` cycles (legal 1..255).
- `RST_CYC`, 2: cycles `cpu_rst_n` is held low after reset or after a load.
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `cmd_run` in 1: start free-running execution.
- `cmd_halt` in 1: stop execution.
- `cmd_step` in 1: execute exactly one instruction.
- `load_valid` in 1: host write beat valid.
- `load_ready` out 1: block accepts a write beat.
- `load_addr` in 4: program address of the beat.
- `load_data` in 8: instruction byte.
- `load_last` in 1: final beat of the program.
- `mem_we` out 1: program-memory write strobe.
- `mem_waddr` out 4: program-memory write address.
- `mem_wdata` out 8: program-memory write data.
- `cpu_en` out 1: core clock enable, one cycle per instruction.
- `cpu_rst_n` out 1: core reset, active-low.
- `cpu_pc` in 4: current core program counter.
- `brk_valid` in 1: breakpoint armed (`CPU_RUN_CTRL_BRK_EN` only).
- `brk_addr` in 4: breakpoint address (`CPU_RUN_CTRL_BRK_EN` only).
- `brk_hit` out 1: sticky breakpoint flag (tied 0 without macro).
- `state` out 2: HALT=0, RUN=1, LOAD=2, CLR=3.

## Operation
- States: CLR, HALT, RUN, LOAD. STEP is a single-cycle action in HALT, not a state.
- CLR: `cpu_rst_n`=0, `cpu_en`=0, `load_ready`=0; after `RST_CYC` cycles → HALT.
- HALT: `load_ready`=1. Command priority: `load_valid` > `cmd_halt` > `cmd_step` > `cmd_run`.
  - `load_valid` → beat accepted, → LOAD.
  - `cmd_step` → `cpu_en`=1 in the next cycle only; remain HALT.
  - `cmd_run` → RUN, prescaler cleared to 0.
- RUN: prescaler counts 0..`DIV`-1; `cpu_en`=1 in the cycle the count equals `DIV`-1, then wraps to 0. `cmd_halt` → HALT next cycle with no further pulse; a pulse due in that same cycle is suppressed. `cmd_step`/`cmd_run` ignored. `load_ready`=0.
- LOAD: `load_ready`=1, `cpu_en`=0. Each beat with `load_valid&&load_ready` drives `mem_we`=1, `mem_waddr`=`load_addr`, `mem_wdata`=`load_data` in the following cycle. Beat with `load_last` → CLR. Commands ignored. Unwritten addresses keep old content.
- `DIV`=1: `cpu_en` high every RUN cycle.

## Timing
- After any cycle with `reset`=1: state=CLR, `cpu_en`=0, `cpu_rst_n`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `load_ready`=0, `brk_hit`=0, prescaler=0.
- Reset during LOAD or RUN aborts immediately; a write registered in the reset cycle is dropped (`mem_we`=0).
- Command sampled at edge N → state change visible after edge N+1; all outputs registered.
- Write latency: handshake at edge N → `mem_we` high during cycle N+1, exactly one cycle per beat; back-to-back beats give back-to-back strobes.
- Step: command at edge N → `cpu_en` high during cycle N+1 only.
- RUN: first `cpu_en` high `DIV` cycles after entering RUN; period `DIV`.
- Load completion: last beat at edge N → `mem_we` during N+1, CLR from N+1 for `RST_CYC` cycles, HALT after.

## Configuration
- `CPU_RUN_CTRL_BRK_EN` defined: in RUN, on a cycle where a pulse is due and `brk_valid`=1 and `cpu_pc`==`brk_addr`, the pulse is suppressed, state → HALT, `brk_hit` set. The check is skipped for the first pulse after entering RUN, so run resumes past the breakpoint. Steps never break. `brk_hit` clears on an accepted `cmd_run`, `cmd_step` or load beat.
- Undefined: breakpoint logic absent, `brk_valid`/`brk_addr` unused, `brk_hit` constant 0.

## Test plan
- Reset 1 cycle, release → `cpu_rst_n`=0 for 2 cycles, state=HALT, `load_ready`=1, `cpu_en`=0 throughout.
- Load 3 beats (0x0→0x31, 0x1→0xB3, 0xF→0xF0, last on 3rd) → three consecutive `mem_we` strobes with matching addr/data, then `cpu_rst_n` low 2 cycles, HALT.
- `DIV`=4, `cmd_run`, 12 cycles, `cmd_halt` → `cpu_en` high on RUN cycles 4, 8, 12 only; no pulse after halt.
- `cmd_step` in HALT → exactly one `cpu_en` cycle; simultaneous `cmd_step`+`cmd_run` → step only, stays HALT.
- `reset` mid-LOAD (beat at edge N, reset at N) → `mem_we`=0, state CLR, subsequent `load_valid` held off until HALT.
- `CPU_RUN_CTRL_BRK_EN`, `brk_addr`=5, run from pc 0 → halt with `cpu_pc`=5, `brk_hit`=1; `cmd_run` again → `brk_hit`=0, execution continues past 5.
